vector_memory_mb: RTL
=====================

Name: vector_memory_mb

Overview:
- Next-generation lane-parallel vector scratchpad: NUM_ELEM independent banks, one per SIMD lane; each bank has one read and one write port per cycle.
- Adds sub-word write masks, a per-lane read-valid pipeline with configurable latency, defined same-address read/write collision behaviour, and a hardware zero-fill (init) engine.
- Sits between the vector datapath lanes and on-chip vector storage.

Parameters:
- DATA_WIDTH, 16, bits per lane word.
- ADDR_WIDTH, 12, bank address bits; DEPTH = 2**ADDR_WIDTH words per bank.
- NUM_ELEM, 16, number of lanes/banks.
- MASK_GRAN, 8, bits per write-mask bit; must divide DATA_WIDTH; MASK_W = DATA_WIDTH/MASK_GRAN.
- READ_LATENCY, 1, read request to data cycles; legal values 1 or 2.
- RDW_MODE, 0, same-cycle same-address read/write: 0 = write-first (forward new data), 1 = read-first (old data).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- read_req  in  NUM_ELEM  per-lane read strobe.
- read_addr  in  ADDR_WIDTH*NUM_ELEM  lane g at [g*ADDR_WIDTH +: ADDR_WIDTH].
- read_data  out  DATA_WIDTH*NUM_ELEM  lane g at [g*DATA_WIDTH +: DATA_WIDTH].
- read_valid  out  NUM_ELEM  per-lane data-valid.
- write_req  in  NUM_ELEM  per-lane write strobe.
- write_addr  in  ADDR_WIDTH*NUM_ELEM  per-lane write address.
- write_data  in  DATA_WIDTH*NUM_ELEM  per-lane write data.
- write_mask  in  MASK_W*NUM_ELEM  per-lane sub-word enable; bit k covers data bits [k*MASK_GRAN +: MASK_GRAN].
- init_start  in  1  pulse; starts zero-fill of all banks.
- init_busy  out  1  high while zero-fill is in progress.
- init_done  out  1  one-cycle pulse when zero-fill completes.

Behaviour:
- Reset (reset low, asynchronous): read_data=0, read_valid=0, init_busy=0, init_done=0; FSM to IDLE; fill counter=0. Array contents are not reset.
- Read timing:
  - read_req[g] sampled at edge t -> read_valid[g]=1 and read_data lane g valid after edge t+READ_LATENCY-1, i.e. visible in cycle t+READ_LATENCY.
  - read_valid[g] is high for exactly one cycle per request.
  - read_data lane g holds its last value while read_valid[g]=0.
  - Fully pipelined: one request per lane per cycle, no stalls.
- Write:
  - Committed at the sampling edge; only masked-in chunks change.
  - write_req with all-zero mask changes nothing.
  - A read issued the cycle after a write to the same address returns the new data in both modes.
- Collision (same lane, same cycle, read_addr==write_addr, both req):
  - RDW_MODE 0: returns merged word (new data in masked-in chunks, old data elsewhere).
  - RDW_MODE 1: returns the pre-write word.
- Lanes are fully independent; no cross-lane arbitration.
- Init FSM:
  - IDLE: init_start=1 -> FILL with counter=0. init_start in any other state is ignored.
  - FILL: init_busy=1; writes 0 to address counter in every bank, full mask; counter++ each cycle. At counter==DEPTH-1 -> DONE.
  - DONE: init_done=1 for one cycle; init_busy=0; -> IDLE.
  - A full fill takes DEPTH cycles in FILL plus one DONE cycle.
- During FILL, external read_req and write_req are dropped: no array effect, no read_valid.
- Reads accepted before FILL entry complete normally and return pre-fill data.
- Reset asserted mid-FILL: immediate return to IDLE, init_busy=0; contents partially cleared and unspecified.
- Counter wrap: the counter never wraps; the FSM exits FILL at DEPTH-1.

Decomposition:
- Shared package: MASK_W derivation, init FSM state encoding (IDLE/FILL/DONE), legal READ_LATENCY and RDW_MODE constants.
- Sub-module vector_memory_mb_bank, instantiated per lane. It contains:
  - storage array;
  - masked write logic;
  - collision/forwarding mux;
  - read-valid/data pipeline.
- The init FSM and counter live once in the top level and override each bank's write port.

Test Plan:
- Lane 3 write addr 0x010 data 0xBEEF mask 2'b11; next cycle read 0x010 -> read_valid[3]=1 and data 0xBEEF at cycle +READ_LATENCY; other lanes' read_valid=0.
- Prior word 0xBEEF, write 0x1234 mask 2'b01 -> readback 0xBE34; write mask 2'b00 -> word unchanged.
- Same-cycle read/write addr 0x020, old 0x1111, new 0x2222 full mask: RDW_MODE 0 -> 0x2222; RDW_MODE 1 -> 0x1111; following read -> 0x2222.
- All lanes read every cycle for 20 cycles, addresses 0..19, READ_LATENCY=2 -> read_valid continuous for 20 cycles starting 2 cycles after the first request, data in order.
- init_start with ADDR_WIDTH=4 -> init_busy high 16 cycles, init_done pulse on cycle 17; writes issued during FILL dropped; every address in every bank reads 0.
- Reset low at FILL counter=5 -> init_busy=0, read_valid=0 immediately; after release, init_start restarts fill from counter 0.

Source files
------------

// File: rtl/vector_memory_mb_pkg.sv
// Shared definitions for the lane-parallel vector scratchpad: init FSM encoding,
// read-latency / collision-mode constants and the mask-width helper.
package vector_memory_mb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } init_state_e;

  localparam int READ_LAT_MIN    = 1;
  localparam int READ_LAT_MAX    = 2;
  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;

  function automatic int calc_mask_w(input int data_width, input int mask_gran);
    return data_width / mask_gran;
  endfunction

endpackage

// File: rtl/vector_memory_mb_if.sv
// Lane-packed request/response bus between the vector datapath and the scratchpad.
interface vector_memory_mb_if
  import vector_memory_mb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_ELEM   = 16,
  parameter int MASK_GRAN  = 8
);
  localparam int MASK_W = calc_mask_w(DATA_WIDTH, MASK_GRAN);

  logic [NUM_ELEM-1:0]            read_req;
  logic [ADDR_WIDTH*NUM_ELEM-1:0] read_addr;
  logic [DATA_WIDTH*NUM_ELEM-1:0] read_data;
  logic [NUM_ELEM-1:0]            read_valid;
  logic [NUM_ELEM-1:0]            write_req;
  logic [ADDR_WIDTH*NUM_ELEM-1:0] write_addr;
  logic [DATA_WIDTH*NUM_ELEM-1:0] write_data;
  logic [MASK_W*NUM_ELEM-1:0]     write_mask;
  logic                           init_start;
  logic                           init_busy;
  logic                           init_done;

  modport master (
    output read_req, read_addr, write_req, write_addr, write_data, write_mask, init_start,
    input  read_data, read_valid, init_busy, init_done
  );

  modport slave (
    input  read_req, read_addr, write_req, write_addr, write_data, write_mask, init_start,
    output read_data, read_valid, init_busy, init_done
  );

endinterface

// File: rtl/vector_memory_mb_bank.sv
// One lane's storage bank: masked write port, same-address collision mux and a
// 1- or 2-stage read pipeline whose output word holds between valid pulses.
module vector_memory_mb_bank
  import vector_memory_mb_pkg::*;
#(
  parameter int  DATA_WIDTH   = 16,
  parameter int  ADDR_WIDTH   = 12,
  parameter int  MASK_GRAN    = 8,
  parameter int  READ_LATENCY = 1,
  parameter int  RDW_MODE     = 0,
  localparam int MASK_W       = calc_mask_w(DATA_WIDTH, MASK_GRAN),
  localparam int DEPTH        = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [MASK_W-1:0]     wr_mask
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] fwd_word;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_valid;

  // NOTE: the array has no reset branch; clearing it is the init engine's job,
  // and a reset term here would turn the RAM into thousands of flops.
  always_ff @(posedge clk) begin
    if (wr_req) begin
      for (int k = 0; k < MASK_W; k++) begin
        if (wr_mask[k]) mem[wr_addr][k*MASK_GRAN +: MASK_GRAN] <= wr_data[k*MASK_GRAN +: MASK_GRAN];
      end
    end
  end

  // Write-first merges the in-flight chunks over the stored word; read-first
  // simply returns the stored word.
  always_comb begin
    fwd_word = mem[rd_addr];
    if (RDW_MODE == RDW_WRITE_FIRST && wr_req && wr_addr == rd_addr) begin
      for (int k = 0; k < MASK_W; k++) begin
        if (wr_mask[k]) fwd_word[k*MASK_GRAN +: MASK_GRAN] = wr_data[k*MASK_GRAN +: MASK_GRAN];
      end
    end
  end

  if (READ_LATENCY == READ_LAT_MAX) begin : g_lat2
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s1_valid <= 1'b0;
        s1_data  <= '0;
      end else begin
        s1_valid <= rd_req;
        if (rd_req) s1_data <= fwd_word;
      end
    end
  end else begin : g_lat1
    assign s1_valid = rd_req;
    assign s1_data  = fwd_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= s1_valid;
      if (s1_valid) rd_data <= s1_data;
    end
  end

endmodule

// File: rtl/vector_memory_mb.sv
// Lane-parallel vector scratchpad: NUM_ELEM independent banks plus a shared
// zero-fill engine that takes over every bank's write port while filling.
module vector_memory_mb
  import vector_memory_mb_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 12,
  parameter int NUM_ELEM     = 16,
  parameter int MASK_GRAN    = 8,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input logic               clk,
  input logic               reset,
  vector_memory_mb_if.slave bus
);

  localparam int MASK_W = calc_mask_w(DATA_WIDTH, MASK_GRAN);

  init_state_e           state, state_next;
  logic [ADDR_WIDTH-1:0] fill_cnt, fill_cnt_next;
  logic                  filling, done_c;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      fill_cnt <= '0;
    end else begin
      state    <= state_next;
      fill_cnt <= fill_cnt_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    fill_cnt_next = fill_cnt;
    filling       = 1'b0;
    done_c        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.init_start) begin
          state_next    = ST_FILL;
          fill_cnt_next = '0;
        end
      end
      ST_FILL: begin
        filling = 1'b1;
        if (&fill_cnt) state_next = ST_DONE;
        else           fill_cnt_next = fill_cnt + ADDR_WIDTH'(1);
      end
      ST_DONE: begin
        done_c     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.init_busy = filling;
  assign bus.init_done = done_c;

  for (genvar g = 0; g < NUM_ELEM; g++) begin : g_lane
    vector_memory_mb_bank #(
      .DATA_WIDTH  (DATA_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .MASK_GRAN   (MASK_GRAN),
      .READ_LATENCY(READ_LATENCY),
      .RDW_MODE    (RDW_MODE)
    ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .rd_req  (bus.read_req[g] & ~filling),
      .rd_addr (bus.read_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .rd_data (bus.read_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .rd_valid(bus.read_valid[g]),
      .wr_req  (filling | bus.write_req[g]),
      .wr_addr (filling ? fill_cnt : bus.write_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .wr_data (filling ? '0 : bus.write_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .wr_mask (filling ? '1 : bus.write_mask[g*MASK_W +: MASK_W])
    );
  end

endmodule
